// File: rtl/uart_pkg.sv
// Shared definitions for the UART framing receiver: state encoding,
// default sync marker, output word geometry and a byte-lane mask helper.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    ABORT
  } uart_frame_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         WORD_W            = 32;
  localparam int         LANES             = WORD_W / 8;

  // Contiguous keep mask for n bytes held (0..4) starting at lane 0.
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] n);
    logic [LANES-1:0] m;
    case (n)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Loadable down-counter used as the inter-byte timeout. Reloads to COUNT on
// load, otherwise counts down to zero and holds; expired is high at zero.
module uart_frame_timer #(
  parameter int COUNT = 3000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Count down between reloads, saturating at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_W'(COUNT);
    end else if (load) begin
      count <= CNT_W'(COUNT);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts for SYNC_BYTE, reads LEN, packs LEN payload bytes
// little-endian into 32-bit AXI-Stream words and checks the trailing XOR
// checksum. tuser on the tlast word marks a bad or aborted frame.
// Optional feature macro: UART_FRAME_TIMEOUT_EN (inter-byte timeout/abort).
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 3000
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic [7:0]        s_data_tdata,
  input  logic              s_data_tvalid,
  output logic              s_data_tready,
  output logic [WORD_W-1:0] m_word_tdata,
  output logic [LANES-1:0]  m_word_tkeep,
  output logic              m_word_tlast,
  output logic              m_word_tuser,
  output logic              m_word_tvalid,
  input  logic              m_word_tready,
  output logic              drop_pulse
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("uart_frame_rx: TIMEOUT_CYCLES must be within 1..65535");
  end

  uart_frame_state_t state, state_n;

  logic [WORD_W-1:0] pack, pack_n, pack_ins, pack_base;
  logic [2:0]        pack_cnt, pack_cnt_n;
  logic              pack_full, pack_full_n;
  logic [7:0]        cnt, cnt_n;
  logic [7:0]        csum, csum_n;
  logic [WORD_W-1:0] data_n;
  logic [LANES-1:0]  keep_n;
  logic              last_n, user_n, vld_n, drop_n;
  logic [1:0]        lane;
  logic              out_free, byte_hs, timeout, quiet_abort, mismatch;

  assign out_free      = !m_word_tvalid || m_word_tready;
  // Stall only when a finished word or the closing word has nowhere to go.
  assign s_data_tready = !((pack_full || state == CSUM) && !out_free);
  assign byte_hs       = s_data_tvalid && s_data_tready;
  assign lane          = pack_full ? 2'd0 : pack_cnt[1:0];
  assign pack_base     = pack_full ? '0 : pack;
  assign pack_ins      = pack_base | (WORD_W'(s_data_tdata) << {lane, 3'b000});
  assign mismatch      = (s_data_tdata != csum);

`ifdef UART_FRAME_TIMEOUT_EN
  logic expired, got_byte;

  uart_frame_timer #(
    .COUNT (TIMEOUT_CYCLES),
    .CNT_W (16)
  ) u_timer (
    .clk     (aclk),
    .rst     (arst),
    .load    (byte_hs || state == HUNT),
    .expired (expired)
  );

  // Remember whether this frame has received any payload byte yet.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      got_byte <= 1'b0;
    end else if (state != PAYLOAD) begin
      got_byte <= 1'b0;
    end else if (byte_hs) begin
      got_byte <= 1'b1;
    end
  end

  assign timeout     = expired && (state != HUNT);
  assign quiet_abort = !got_byte;
`else
  assign timeout     = 1'b0;
  assign quiet_abort = 1'b1;
`endif

  // State register.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and next values for pack, checksum and output register.
  always_comb begin
    state_n     = state;
    pack_n      = pack;
    pack_cnt_n  = pack_cnt;
    pack_full_n = pack_full;
    cnt_n       = cnt;
    csum_n      = csum;
    data_n      = m_word_tdata;
    keep_n      = m_word_tkeep;
    last_n      = m_word_tlast;
    user_n      = m_word_tuser;
    vld_n       = m_word_tvalid && !m_word_tready;
    drop_n      = 1'b0;

    // A completed word parked in the pack register moves out once room opens.
    if (state == PAYLOAD && pack_full && out_free) begin
      data_n      = pack;
      keep_n      = '1;
      last_n      = 1'b0;
      user_n      = 1'b0;
      vld_n       = 1'b1;
      pack_n      = '0;
      pack_cnt_n  = '0;
      pack_full_n = 1'b0;
    end

    case (state)
      HUNT: begin
        if (byte_hs && s_data_tdata == SYNC_BYTE) begin
          state_n = LEN;
        end
      end
      LEN: begin
        if (byte_hs) begin
          if (s_data_tdata == 8'd0) begin
            drop_n  = 1'b1;
            state_n = HUNT;
          end else begin
            cnt_n       = s_data_tdata;
            csum_n      = s_data_tdata;
            pack_n      = '0;
            pack_cnt_n  = '0;
            pack_full_n = 1'b0;
            state_n     = PAYLOAD;
          end
        end else if (timeout) begin
          drop_n  = 1'b1;
          state_n = HUNT;
        end
      end
      PAYLOAD: begin
        if (byte_hs) begin
          csum_n = csum ^ s_data_tdata;
          cnt_n  = cnt - 8'd1;
          if (cnt != 8'd1 && lane == 2'd3 && out_free) begin
            data_n     = pack_ins;
            keep_n     = '1;
            last_n     = 1'b0;
            user_n     = 1'b0;
            vld_n      = 1'b1;
            pack_n     = '0;
            pack_cnt_n = '0;
          end else begin
            pack_n      = pack_ins;
            pack_cnt_n  = {1'b0, lane} + 3'd1;
            pack_full_n = (cnt != 8'd1) && (lane == 2'd3);
          end
          if (cnt == 8'd1) begin
            state_n = CSUM;
          end
        end else if (timeout) begin
          if (quiet_abort) begin
            drop_n  = 1'b1;
            state_n = HUNT;
          end else begin
            state_n = ABORT;
          end
        end
      end
      CSUM: begin
        if (byte_hs) begin
          data_n      = pack;
          keep_n      = lane_mask(pack_cnt);
          last_n      = 1'b1;
          user_n      = mismatch;
          vld_n       = 1'b1;
          drop_n      = mismatch;
          pack_n      = '0;
          pack_cnt_n  = '0;
          pack_full_n = 1'b0;
          state_n     = HUNT;
        end
      end
      ABORT: begin
        if (out_free) begin
          data_n      = pack;
          keep_n      = lane_mask(pack_cnt);
          last_n      = 1'b1;
          user_n      = 1'b1;
          vld_n       = 1'b1;
          drop_n      = 1'b1;
          pack_n      = '0;
          pack_cnt_n  = '0;
          pack_full_n = 1'b0;
          state_n     = HUNT;
        end
      end
      default: begin
        state_n = HUNT;
      end
    endcase
  end

  // Datapath and output registers; everything clears on reset.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      pack          <= '0;
      pack_cnt      <= '0;
      pack_full     <= 1'b0;
      cnt           <= '0;
      csum          <= '0;
      m_word_tdata  <= '0;
      m_word_tkeep  <= '0;
      m_word_tlast  <= 1'b0;
      m_word_tuser  <= 1'b0;
      m_word_tvalid <= 1'b0;
      drop_pulse    <= 1'b0;
    end else begin
      pack          <= pack_n;
      pack_cnt      <= pack_cnt_n;
      pack_full     <= pack_full_n;
      cnt           <= cnt_n;
      csum          <= csum_n;
      m_word_tdata  <= data_n;
      m_word_tkeep  <= keep_n;
      m_word_tlast  <= last_n;
      m_word_tuser  <= user_n;
      m_word_tvalid <= vld_n;
      drop_pulse    <= drop_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed testbench for uart_frame_rx. Words are recorded as
// {tuser, tlast, tkeep, tdata} and compared with hand-computed values.
module tb_uart_frame_rx;

  logic        aclk;
  logic        arst;
  logic [7:0]  s_data_tdata;
  logic        s_data_tvalid;
  logic        s_data_tready;
  logic [31:0] m_word_tdata;
  logic [3:0]  m_word_tkeep;
  logic        m_word_tlast;
  logic        m_word_tuser;
  logic        m_word_tvalid;
  logic        m_word_tready;
  logic        drop_pulse;

  int          checks = 0;
  int          errors = 0;
  int          drops  = 0;
  bit          saw_stall = 1'b0;
  logic [37:0] got_q[$];
  logic [37:0] cur;
  logic [37:0] held;
  bit          held_v = 1'b0;

  uart_frame_rx dut (
    .aclk          (aclk),
    .arst          (arst),
    .s_data_tdata  (s_data_tdata),
    .s_data_tvalid (s_data_tvalid),
    .s_data_tready (s_data_tready),
    .m_word_tdata  (m_word_tdata),
    .m_word_tkeep  (m_word_tkeep),
    .m_word_tlast  (m_word_tlast),
    .m_word_tuser  (m_word_tuser),
    .m_word_tvalid (m_word_tvalid),
    .m_word_tready (m_word_tready),
    .drop_pulse    (drop_pulse)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Collect words, count drop pulses, watch stalls and output stability.
  always @(negedge aclk) begin
    cur = {m_word_tuser, m_word_tlast, m_word_tkeep, m_word_tdata};
    if (drop_pulse === 1'b1) drops++;
    if (s_data_tvalid && s_data_tready === 1'b0) saw_stall = 1'b1;
    if (held_v) begin
      checks++;
      if (m_word_tvalid !== 1'b1 || cur !== held) begin
        errors++;
        $display("FAIL hold_stable got vld=%b %h want vld=1 %h", m_word_tvalid, cur, held);
      end
    end
    if (m_word_tvalid === 1'b1 && m_word_tready === 1'b1) got_q.push_back(cur);
    held_v = (m_word_tvalid === 1'b1) && (m_word_tready === 1'b0);
    held   = cur;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_data_tdata  = b;
    s_data_tvalid = 1'b1;
    @(negedge aclk);
    while (s_data_tready !== 1'b1 && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_stall byte %h not accepted within 2000 cycles", b);
    end
    @(posedge aclk);
    #1;
    s_data_tvalid = 1'b0;
  endtask

  task automatic start_test();
    idle(4);
    got_q.delete();
    drops = 0;
  endtask

  task automatic test_reset();
    arst = 1'b0;
    s_data_tvalid = 1'b0;
    s_data_tdata  = 8'h00;
    m_word_tready = 1'b1;
    #2 arst = 1'b1;
    @(negedge aclk);
    checks++;
    if (m_word_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_word_tvalid); end
    checks++;
    if (m_word_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_word_tdata); end
    checks++;
    if ({m_word_tkeep, m_word_tlast, m_word_tuser} !== 6'b0) begin
      errors++; $display("FAIL rst_ctrl got keep=%h last=%b user=%b want 0", m_word_tkeep, m_word_tlast, m_word_tuser);
    end
    checks++;
    if (drop_pulse !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", drop_pulse); end
    @(posedge aclk);
    #1 arst = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_data_tready !== 1'b1) begin errors++; $display("FAIL rst_tready got %b want 1", s_data_tready); end
  endtask

  task automatic test_single_word();
    logic [7:0]  f[7] = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
    logic [37:0] w;
    start_test();
    foreach (f[i]) send_byte(f[i]);
    idle(5);
    checks++;
    if (got_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (w !== {1'b0, 1'b1, 4'hF, 32'h44332211}) begin
      errors++; $display("FAIL single_word got %h want %h", w, {1'b0, 1'b1, 4'hF, 32'h44332211});
    end
    checks++;
    if (drops !== 0) begin errors++; $display("FAIL single_drop got %0d want 0", drops); end
  endtask

  task automatic test_partial_word();
    logic [7:0]  f[8] = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04};
    logic [37:0] exp[2] = '{{1'b0, 1'b0, 4'hF, 32'h04030201}, {1'b0, 1'b1, 4'h1, 32'h00000005}};
    logic [37:0] w;
    start_test();
    foreach (f[i]) send_byte(f[i]);
    idle(5);
    checks++;
    if (got_q.size() !== 2) begin errors++; $display("FAIL partial_count got %0d want 2", got_q.size()); end
    foreach (exp[i]) begin
      w = (got_q.size() > i) ? got_q[i] : 'x;
      checks++;
      if (w !== exp[i]) begin errors++; $display("FAIL partial_word%0d got %h want %h", i, w, exp[i]); end
    end
    checks++;
    if (drops !== 0) begin errors++; $display("FAIL partial_drop got %0d want 0", drops); end
  endtask

  task automatic test_bad_csum();
    logic [7:0]  f[5] = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
    logic [37:0] w;
    start_test();
    foreach (f[i]) send_byte(f[i]);
    idle(5);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (got_q.size() !== 1 || w !== {1'b1, 1'b1, 4'h3, 32'h0000BBAA}) begin
      errors++; $display("FAIL badcsum_word got n=%0d %h want n=1 %h", got_q.size(), w, {1'b1, 1'b1, 4'h3, 32'h0000BBAA});
    end
    checks++;
    if (drops !== 1) begin errors++; $display("FAIL badcsum_drop got %0d want 1", drops); end
  endtask

  task automatic test_noise_len0();
    logic [7:0]  f[9] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    logic [37:0] w;
    start_test();
    foreach (f[i]) send_byte(f[i]);
    idle(5);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (got_q.size() !== 1 || w !== {1'b0, 1'b1, 4'h1, 32'h0000007E}) begin
      errors++; $display("FAIL noise_word got n=%0d %h want n=1 %h", got_q.size(), w, {1'b0, 1'b1, 4'h1, 32'h0000007E});
    end
    checks++;
    if (drops !== 1) begin errors++; $display("FAIL noise_drop got %0d want 1", drops); end
  endtask

  task automatic test_backpressure();
    logic [37:0] exp[3] = '{{1'b0, 1'b0, 4'hF, 32'h04030201},
                            {1'b0, 1'b0, 4'hF, 32'h08070605},
                            {1'b0, 1'b1, 4'hF, 32'h0C0B0A09}};
    logic [37:0] w;
    start_test();
    saw_stall = 1'b0;
    fork
      begin
        send_byte(8'hA5);
        send_byte(8'h0C);
        for (int i = 1; i <= 12; i++) send_byte(8'(i));
        send_byte(8'h00);
      end
      begin
        idle(6);
        m_word_tready = 1'b0;
        idle(50);
        m_word_tready = 1'b1;
      end
    join
    idle(5);
    checks++;
    if (saw_stall !== 1'b1) begin errors++; $display("FAIL bp_stall got %b want 1", saw_stall); end
    checks++;
    if (got_q.size() !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_q.size()); end
    foreach (exp[i]) begin
      w = (got_q.size() > i) ? got_q[i] : 'x;
      checks++;
      if (w !== exp[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, w, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  f[14] = '{8'hA5, 8'h01, 8'h7E, 8'h7F,
                           8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13,
                           8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
    logic [37:0] exp[3] = '{{1'b0, 1'b1, 4'h1, 32'h0000007E},
                            {1'b0, 1'b1, 4'h3, 32'h0000BBAA},
                            {1'b0, 1'b1, 4'h3, 32'h0000A5A5}};
    logic [37:0] w;
    start_test();
    foreach (f[i]) send_byte(f[i]);
    idle(5);
    checks++;
    if (got_q.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", got_q.size()); end
    foreach (exp[i]) begin
      w = (got_q.size() > i) ? got_q[i] : 'x;
      checks++;
      if (w !== exp[i]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, w, exp[i]); end
    end
    checks++;
    if (drops !== 0) begin errors++; $display("FAIL b2b_drop got %0d want 0", drops); end
  endtask

  task automatic test_max_len();
    logic [37:0] w;
    start_test();
    send_byte(8'hA5);
    send_byte(8'hFF);
    for (int i = 0; i < 255; i++) send_byte(8'(i));
    send_byte(8'h00);
    idle(5);
    checks++;
    if (got_q.size() !== 64) begin errors++; $display("FAIL maxlen_count got %0d want 64", got_q.size()); end
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (w !== {1'b0, 1'b0, 4'hF, 32'h03020100}) begin
      errors++; $display("FAIL maxlen_first got %h want %h", w, {1'b0, 1'b0, 4'hF, 32'h03020100});
    end
    w = (got_q.size() > 63) ? got_q[63] : 'x;
    checks++;
    if (w !== {1'b0, 1'b1, 4'h7, 32'h00FEFDFC}) begin
      errors++; $display("FAIL maxlen_last got %h want %h", w, {1'b0, 1'b1, 4'h7, 32'h00FEFDFC});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  f[4] = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    logic [37:0] w;
    start_test();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    arst = 1'b1;
    @(negedge aclk);
    checks++;
    if (m_word_tvalid !== 1'b0 || drop_pulse !== 1'b0) begin
      errors++; $display("FAIL midrst_out got vld=%b drop=%b want 0 0", m_word_tvalid, drop_pulse);
    end
    @(posedge aclk);
    #1 arst = 1'b0;
    foreach (f[i]) send_byte(f[i]);
    idle(5);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (got_q.size() !== 1 || w !== {1'b0, 1'b1, 4'h1, 32'h0000007E}) begin
      errors++; $display("FAIL midrst_word got n=%0d %h want n=1 %h", got_q.size(), w, {1'b0, 1'b1, 4'h1, 32'h0000007E});
    end
  endtask

`ifdef UART_FRAME_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0]  f[4] = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    logic [37:0] w;
    start_test();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    idle(3100);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (got_q.size() !== 1 || w !== {1'b1, 1'b1, 4'h1, 32'h00000010}) begin
      errors++; $display("FAIL tmo_word got n=%0d %h want n=1 %h", got_q.size(), w, {1'b1, 1'b1, 4'h1, 32'h00000010});
    end
    checks++;
    if (drops !== 1) begin errors++; $display("FAIL tmo_drop got %0d want 1", drops); end
    start_test();
    foreach (f[i]) send_byte(f[i]);
    idle(5);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (got_q.size() !== 1 || w !== {1'b0, 1'b1, 4'h1, 32'h0000007E}) begin
      errors++; $display("FAIL tmo_next got n=%0d %h want n=1 %h", got_q.size(), w, {1'b0, 1'b1, 4'h1, 32'h0000007E});
    end
    start_test();
    send_byte(8'hA5);
    idle(3100);
    checks++;
    if (got_q.size() !== 0 || drops !== 1) begin
      errors++; $display("FAIL tmo_len got words=%0d drops=%0d want 0 1", got_q.size(), drops);
    end
  endtask
`else
  task automatic test_timeout();
    logic [37:0] w;
    start_test();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    idle(3100);
    checks++;
    if (got_q.size() !== 0 || drops !== 0) begin
      errors++; $display("FAIL stall_idle got words=%0d drops=%0d want 0 0", got_q.size(), drops);
    end
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h03);
    idle(5);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++;
    if (got_q.size() !== 1 || w !== {1'b0, 1'b1, 4'h7, 32'h00302010}) begin
      errors++; $display("FAIL stall_resume got n=%0d %h want n=1 %h", got_q.size(), w, {1'b0, 1'b1, 4'h7, 32'h00302010});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_partial_word();
    test_bad_csum();
    test_noise_len0();
    test_backpressure();
    test_back_to_back();
    test_max_len();
    test_reset_mid_frame();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
